tx_slice_arbiter: RTL
=====================

# tx_slice_arbiter

Arbitrates between the four transmit queues using the per-slice enables of the time-slice generator, granting the transmit controller one queue at a time. A queue is eligible only when it has a frame pending and its slice enable is high. The block tracks each granted transmission through a start/done handshake and aborts transmissions that overrun a programmable microsecond budget. It sits between the time-slice generator and the transmit controller in the xpu.

## Interface
Parameters:
- TMO_W, 16, width of the airtime budget and the microsecond counter.
- CNT_W, 8, width of the saturating timeout-event counter.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset, synchronous, active-low.
- tsf_pulse_1M  in  1  one-cycle pulse per microsecond.
- slice_en  in  4  bit i = slice enable i from the time-slice generator.
- queue_req  in  4  bit i = queue i has a frame pending.
- arb_enable  in  1  global arbitration enable (register bit).
- prio_mode  in  1  0 = round-robin, 1 = fixed priority (queue 3 highest).
- max_tx_us  in  TMO_W  airtime budget in µs; 0 disables the watchdog.
- tx_start_ack  in  1  transmit controller accepts the current grant.
- tx_done  in  1  one-cycle pulse: granted transmission finished.
- grant_valid  out  1  grant offered to the transmit controller.
- grant_idx  out  2  queue index of the grant.
- tx_busy  out  1  a granted transmission is in flight.
- tx_abort  out  1  one-cycle pulse: watchdog expired.
- timeout_cnt  out  CNT_W  number of aborts, saturating.

## Operation
- eligible = queue_req & slice_en, evaluated combinationally every cycle.
- States: IDLE, GRANT, BUSY, GAP.
- IDLE: if arb_enable=1 and eligible≠0:
  - Pick a winner and register it into grant_idx.
  - Set grant_valid and go to GRANT.
  - Otherwise stay in IDLE.
- Winner selection:
  - Round-robin: the first eligible index scanning rr_ptr, rr_ptr+1, … modulo 4.
  - Fixed priority: the highest eligible index.
- GRANT:
  - On tx_start_ack=1: clear grant_valid, set tx_busy, clear the µs counter, go to BUSY.
  - Otherwise, if eligible[grant_idx]=0 or arb_enable=0: withdraw (clear grant_valid) and go to IDLE. rr_ptr is unchanged.
  - ack has priority over a withdraw condition in the same cycle.
- BUSY:
  - The µs counter increments on each tsf_pulse_1M and saturates at all-ones.
  - Loss of slice_en, queue_req or arb_enable has no effect in BUSY.
  - On tx_done=1: go to GAP.
  - Else, if max_tx_us≠0 and the counter equals max_tx_us: pulse tx_abort, increment timeout_cnt (saturating), go to GAP.
  - tx_done and expiry in the same cycle: done wins, no abort.
- GAP (exactly one cycle):
  - Clear tx_busy.
  - rr_ptr ← grant_idx+1 (2-bit wrap, 3→0).
  - Go to IDLE.
- tx_done or tx_start_ack arriving outside the state that consumes it is ignored.
- Reset (any state, including mid-transmission): state=IDLE, grant_valid=0, grant_idx=0, tx_busy=0, tx_abort=0, timeout_cnt=0, rr_ptr=0, µs counter=0.

## Timing
- Grant latency: eligible seen in IDLE in cycle N; grant_valid=1 and grant_idx valid from cycle N+1.
- grant_idx is stable while grant_valid=1 and while tx_busy=1.
- Ack sampled in cycle M: grant_valid=0 and tx_busy=1 from M+1.
- Withdraw seen in cycle M: grant_valid=0 from M+1.
- tx_done in cycle D: GAP in D+1 with tx_busy=0. IDLE in D+2, so the earliest next grant_valid is D+3.
- Abort:
  - tx_abort is high in the cycle after the counter reaches max_tx_us.
  - tx_busy falls one cycle after tx_abort.
  - A change of max_tx_us during BUSY takes effect immediately.
- Back-to-back transmissions are separated by at least 2 idle grant cycles.

## Structure
- Shared xpu package holds:
  - The state encoding (IDLE=0, GRANT=1, BUSY=2, GAP=3).
  - NUM_SLICE=4.
  - PRIO_RR / PRIO_FIXED constants.
- One combinational sub-module, rr_pick4 (inputs: 4-bit request, 2-bit pointer, mode; outputs: found, 2-bit index). It is shared by both modes and is instantiated once.
- The FSM, µs counter and timeout counter live in the top module.

## Test plan
- Round-robin fairness: queue_req=4'b1111, slice_en=4'b1111, ack in the cycle after each grant, tx_done 5 cycles later. Required grant sequence: 0,1,2,3,0.
- Fixed priority: prio_mode=1, queue_req=4'b0110. Required: grant_idx=2 every time; after queue_req=4'b0010, grant_idx=1.
- Slice gating and withdraw: queue_req=4'b0001, slice_en=0 gives no grant. Raise slice_en[0]: grant_valid rises 1 cycle later. Drop slice_en[0] before ack: grant_valid falls the next cycle and the next round-robin grant is still queue 0.
- Watchdog: max_tx_us=3, no tx_done. Required: tx_abort pulses for 1 cycle after the 3rd tsf_pulse_1M in BUSY, and timeout_cnt=1. Then repeat with tx_done coincident with expiry: no abort, timeout_cnt unchanged.
- Saturation: force 260 aborts with CNT_W=8. Required: timeout_cnt holds at 255.
- Reset mid-BUSY: rstn=0 for 1 cycle during a transmission. Required: all outputs at their reset values the next cycle, and the next round-robin grant starts from queue 0.

Source files
------------

// File: rtl/tx_slice_arbiter_pkg.sv
// Shared xpu definitions for the transmit slice arbiter: the FSM state encoding,
// the number of slices and the arbitration mode constants.
package tx_slice_arbiter_pkg;

    localparam int   NUM_SLICE  = 4;
    localparam logic PRIO_RR    = 1'b0;
    localparam logic PRIO_FIXED = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BUSY  = 2'd2,
        ST_GAP   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/tx_slice_arbiter_rr_pick4.sv
// Four-way winner picker shared by both arbitration modes. Round-robin scans
// ptr, ptr+1, ... modulo 4; fixed priority takes the highest requesting index.
module rr_pick4
    import tx_slice_arbiter_pkg::*;
(
    input  logic [NUM_SLICE-1:0] req,
    input  logic [1:0]           ptr,
    input  logic                 mode,
    output logic                 found,
    output logic [1:0]           idx
);

    logic [1:0] cand;

    // Later loop iterations override earlier ones, so each scan visits
    // candidates from lowest to highest precedence.
    always_comb begin
        found = |req;
        idx   = 2'd0;
        cand  = 2'd0;
        if (mode == PRIO_FIXED) begin
            for (int i = 0; i < NUM_SLICE; i++) begin
                if (req[i]) idx = 2'(i);
            end
        end else begin
            for (int k = NUM_SLICE - 1; k >= 0; k--) begin
                cand = ptr + 2'(k);
                if (req[cand]) idx = cand;
            end
        end
    end

endmodule

// File: rtl/tx_slice_arbiter.sv
// Transmit slice arbiter: grants one eligible queue at a time to the transmit
// controller, tracks the start/done handshake and aborts transmissions that
// exceed the programmable microsecond airtime budget.
module tx_slice_arbiter
    import tx_slice_arbiter_pkg::*;
#(
    parameter int TMO_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             tsf_pulse_1M,
    input  logic [3:0]       slice_en,
    input  logic [3:0]       queue_req,
    input  logic             arb_enable,
    input  logic             prio_mode,
    input  logic [TMO_W-1:0] max_tx_us,
    input  logic             tx_start_ack,
    input  logic             tx_done,
    output logic             grant_valid,
    output logic [1:0]       grant_idx,
    output logic             tx_busy,
    output logic             tx_abort,
    output logic [CNT_W-1:0] timeout_cnt
);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [3:0]       eligible;
    logic [1:0]       rr_ptr;
    logic [TMO_W-1:0] us_cnt;
    logic             pick_found;
    logic [1:0]       pick_idx;
    logic             start_grant;
    logic             withdraw;
    logic             expired;

    assign eligible    = queue_req & slice_en;
    assign start_grant = arb_enable && pick_found;
    assign withdraw    = !eligible[grant_idx] || !arb_enable;
    // Compared against the live budget so a reprogrammed limit applies at once.
    assign expired     = (max_tx_us != '0) && (us_cnt == max_tx_us);

    rr_pick4 u_pick (
        .req   (eligible),
        .ptr   (rr_ptr),
        .mode  (prio_mode),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; ack beats withdraw and done beats expiry.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start_grant) state_nxt = ST_GRANT;
            ST_GRANT: begin
                if (tx_start_ack)  state_nxt = ST_BUSY;
                else if (withdraw) state_nxt = ST_IDLE;
            end
            ST_BUSY:  if (tx_done || expired) state_nxt = ST_GAP;
            ST_GAP:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Grant, busy and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            grant_valid <= 1'b0;
            grant_idx   <= 2'd0;
            tx_busy     <= 1'b0;
            rr_ptr      <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_grant) begin
                        grant_valid <= 1'b1;
                        grant_idx   <= pick_idx;
                    end
                end
                ST_GRANT: begin
                    if (tx_start_ack) begin
                        grant_valid <= 1'b0;
                        tx_busy     <= 1'b1;
                    end else if (withdraw) begin
                        grant_valid <= 1'b0;
                    end
                end
                // A completed frame drops busy on entry to the gap; an aborted
                // one keeps busy through the abort cycle and drops it on exit.
                ST_BUSY: if (tx_done) tx_busy <= 1'b0;
                ST_GAP: begin
                    tx_busy <= 1'b0;
                    rr_ptr  <= grant_idx + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Microsecond airtime counter, cleared on ack and saturating in BUSY.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            us_cnt <= '0;
        end else if (state == ST_GRANT && tx_start_ack) begin
            us_cnt <= '0;
        end else if (state == ST_BUSY && tsf_pulse_1M && us_cnt != '1) begin
            us_cnt <= us_cnt + TMO_W'(1);
        end
    end

    // Watchdog abort pulse and saturating abort counter.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tx_abort    <= 1'b0;
            timeout_cnt <= '0;
        end else begin
            tx_abort <= 1'b0;
            if (state == ST_BUSY && !tx_done && expired) begin
                tx_abort <= 1'b1;
                if (timeout_cnt != '1) timeout_cnt <= timeout_cnt + CNT_W'(1);
            end
        end
    end

endmodule
